// File: rtl/hex_scan_scheduler_pkg.sv
// Shared constants for the hex scan scheduler: segment width, blank code and the
// active-low 7-segment map (bit 0 = segment a .. bit 6 = segment g).
package hex_scan_scheduler_pkg;

  localparam int unsigned SEG_W     = 7;
  localparam int unsigned NIBBLE_W  = 4;
  localparam int unsigned WR_IDX_W  = 3;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F = 7'h0E;

  function automatic logic [SEG_W-1:0] seg_of(input logic [NIBBLE_W-1:0] nibble);
    logic [SEG_W-1:0] seg;
    case (nibble)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_scan_scheduler_if.sv
// Write / blank / hold request bus from the lab datapath and the scanned HEX outputs.
interface hex_scan_scheduler_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  import hex_scan_scheduler_pkg::*;

  logic                          wr_en;
  logic [WR_IDX_W-1:0]           wr_idx;
  logic [NIBBLE_W-1:0]           wr_data;
  logic [NUM_DIGITS-1:0]         blank_en;
  logic                          hold;
  logic [SEG_W*NUM_DIGITS-1:0]   hex_out;
  logic                          scan_done;

  modport master (
    output wr_en, wr_idx, wr_data, blank_en, hold,
    input  hex_out, scan_done
  );

  modport slave (
    input  wr_en, wr_idx, wr_data, blank_en, hold,
    output hex_out, scan_done
  );

endinterface

// File: rtl/hex_scan_scheduler_hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment decoder, shared by all slots.
module hex_to_seg
  import hex_scan_scheduler_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_nibble,
  output logic [SEG_W-1:0]    o_seg_c
);

  assign o_seg_c = seg_of(i_nibble);

endmodule

// File: rtl/hex_scan_scheduler.sv
// Round-robin scanner: one slot per DIV cycles is decoded through a single shared
// hex_to_seg and latched into that slot's segment register.
module hex_scan_scheduler
  import hex_scan_scheduler_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIV        = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  hex_scan_scheduler_if.slave  bus
);

  localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned HEX_W  = SEG_W * NUM_DIGITS;

  logic [DIV_W-1:0]    r_div_cnt;
  logic [SLOT_W-1:0]   r_slot;
  logic [NIBBLE_W-1:0] r_digit [NUM_DIGITS];
  logic [HEX_W-1:0]    r_hex;
  logic                r_scan_done;

  logic                w_div_wrap;
  logic                w_tick;
  logic                w_last_slot;
  logic [NIBBLE_W-1:0] w_nibble;
  logic                w_blank;
  logic [SEG_W-1:0]    w_seg;
  logic [SEG_W-1:0]    w_vis_seg;

  assign w_div_wrap  = (r_div_cnt == DIV_W'(DIV - 1));
  assign w_tick      = w_div_wrap && !bus.hold;
  assign w_last_slot = (r_slot == SLOT_W'(NUM_DIGITS - 1));

  // Select the visited slot's nibble and blank request for the shared decoder.
  always_comb begin
    w_nibble = '0;
    w_blank  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_slot == SLOT_W'(k)) begin
        w_nibble = r_digit[k];
        w_blank  = bus.blank_en[k];
      end
    end
  end

  hex_to_seg u_hex_to_seg (
    .i_nibble (w_nibble),
    .o_seg_c  (w_seg)
  );

  assign w_vis_seg = w_blank ? SEG_BLANK : w_seg;

  // Decoder reads the pre-edge nibble, so a same-edge write shows on the next visit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_div_cnt   <= '0;
      r_slot      <= '0;
      r_hex       <= {NUM_DIGITS{SEG_BLANK}};
      r_scan_done <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        r_digit[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (bus.wr_en && (bus.wr_idx == WR_IDX_W'(k))) begin
          r_digit[k] <= bus.wr_data;
        end
      end

      if (!bus.hold) begin
        r_div_cnt   <= w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
        r_scan_done <= w_tick && w_last_slot;
      end

      if (w_tick) begin
        r_slot <= w_last_slot ? '0 : r_slot + SLOT_W'(1);
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (r_slot == SLOT_W'(k)) begin
            r_hex[SEG_W*k +: SEG_W] <= w_vis_seg;
          end
        end
      end
    end
  end

  assign bus.hex_out   = r_hex;
  assign bus.scan_done = r_scan_done;

endmodule

// File: tb/tb_hex_scan_scheduler.sv
// Directed bench for hex_scan_scheduler: a 4-slot/DIV=4 instance and a 1-slot/DIV=1 instance.
module tb_hex_scan_scheduler;

  logic clk;
  logic resetn;
  int   errors;
  int   checks;

  hex_scan_scheduler_if #(.NUM_DIGITS(4)) bus4 ();
  hex_scan_scheduler_if #(.NUM_DIGITS(1)) bus1 ();

  hex_scan_scheduler #(.NUM_DIGITS(4), .DIV(4)) dut4 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus4.slave)
  );

  hex_scan_scheduler #(.NUM_DIGITS(1), .DIV(1)) dut1 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    resetn = 1'b0;
    bus4.wr_en = 1'b0; bus4.wr_idx = 3'd0; bus4.wr_data = 4'h0;
    bus4.blank_en = 4'b0000; bus4.hold = 1'b0;
    bus1.wr_en = 1'b0; bus1.wr_idx = 3'd0; bus1.wr_data = 4'h0;
    bus1.blank_en = 1'b0; bus1.hold = 1'b0;

    // Reset
    tick_n(2);
    chk("reset_hex", bus4.hex_out, {7'h7F, 7'h7F, 7'h7F, 7'h7F});
    chk("reset_done", 28'(bus4.scan_done), 28'd0);
    resetn = 1'b1;

    // 1: write slots 0..3 = 1,2,3,4 on edges 1..4
    bus4.wr_en = 1'b1; bus4.wr_idx = 3'd0; bus4.wr_data = 4'h1; tick_n(1);
    bus4.wr_idx = 3'd1; bus4.wr_data = 4'h2; tick_n(1);
    bus4.wr_idx = 3'd2; bus4.wr_data = 4'h3; tick_n(1);
    bus4.wr_idx = 3'd3; bus4.wr_data = 4'h4; tick_n(1);
    bus4.wr_en = 1'b0;
    chk("first_visit", bus4.hex_out, {7'h7F, 7'h7F, 7'h7F, 7'h79});
    tick_n(11);
    chk("done_pre16", 28'(bus4.scan_done), 28'd0);
    tick_n(1);
    chk("scan16_hex", bus4.hex_out, {7'h19, 7'h30, 7'h24, 7'h79});
    chk("done_at16", 28'(bus4.scan_done), 28'd1);
    tick_n(1);
    chk("done_17", 28'(bus4.scan_done), 28'd0);

    // 2: blank slot 2 (visited at edge 28)
    bus4.blank_en = 4'b0100;
    tick_n(11);
    chk("blank_slot2", bus4.hex_out, {7'h19, 7'h7F, 7'h24, 7'h79});

    // 3: write slot 1 = 8 on edge 40, which is also slot 1's visit
    tick_n(11);
    bus4.blank_en = 4'b0000;
    bus4.wr_en = 1'b1; bus4.wr_idx = 3'd1; bus4.wr_data = 4'h8;
    tick_n(1);
    bus4.wr_en = 1'b0;
    chk("same_edge_old", bus4.hex_out, {7'h19, 7'h7F, 7'h24, 7'h79});
    tick_n(4);
    chk("unblank_slot2", bus4.hex_out, {7'h19, 7'h30, 7'h24, 7'h79});
    tick_n(11);
    chk("slot1_e55", bus4.hex_out, {7'h19, 7'h30, 7'h24, 7'h79});
    tick_n(1);
    chk("slot1_new", bus4.hex_out, {7'h19, 7'h30, 7'h00, 7'h79});

    // 4: hold from edge 59 to 78 (div_cnt frozen at 2, slot 2 pending); write slot 2 = 6 under hold
    tick_n(2);
    bus4.hold = 1'b1;
    bus4.wr_en = 1'b1; bus4.wr_idx = 3'd2; bus4.wr_data = 4'h6;
    tick_n(1);
    bus4.wr_en = 1'b0;
    tick_n(19);
    chk("hold_hex", bus4.hex_out, {7'h19, 7'h30, 7'h00, 7'h79});
    chk("hold_done", 28'(bus4.scan_done), 28'd0);
    bus4.hold = 1'b0;
    tick_n(1);
    chk("resume_e79", bus4.hex_out, {7'h19, 7'h30, 7'h00, 7'h79});
    tick_n(1);
    chk("resume_e80", bus4.hex_out, {7'h19, 7'h02, 7'h00, 7'h79});
    tick_n(4);
    chk("resume_done", 28'(bus4.scan_done), 28'd1);

    // 5: out-of-range write, then slot 0 = F (slot 0 visited at edge 88)
    bus4.wr_en = 1'b1; bus4.wr_idx = 3'd5; bus4.wr_data = 4'h7; tick_n(1);
    bus4.wr_idx = 3'd0; bus4.wr_data = 4'hF; tick_n(1);
    bus4.wr_en = 1'b0;
    tick_n(2);
    chk("slot0_F", bus4.hex_out, {7'h19, 7'h02, 7'h00, 7'h0E});
    tick_n(4);
    chk("idx5_ignored", bus4.hex_out, {7'h19, 7'h02, 7'h00, 7'h0E});

    // Reset mid-scan
    tick_n(2);
    resetn = 1'b0;
    tick_n(1);
    chk("midreset_hex", bus4.hex_out, {7'h7F, 7'h7F, 7'h7F, 7'h7F});
    chk("midreset_done", 28'(bus4.scan_done), 28'd0);
    chk("d1_reset_hex", 28'(bus1.hex_out), 28'h7F);
    chk("d1_reset_done", 28'(bus1.scan_done), 28'd0);
    resetn = 1'b1;

    // 6: DIV=1, NUM_DIGITS=1 instance in parallel with the restarted 4-slot scan
    bus1.wr_en = 1'b1; bus1.wr_idx = 3'd0; bus1.wr_data = 4'h9;
    tick_n(1);
    bus1.wr_en = 1'b0;
    chk("d1_old", 28'(bus1.hex_out), 28'h40);
    chk("d1_done1", 28'(bus1.scan_done), 28'd1);
    tick_n(1);
    chk("d1_new", 28'(bus1.hex_out), 28'h10);
    chk("d1_done2", 28'(bus1.scan_done), 28'd1);
    tick_n(1);
    chk("restart_e3", bus4.hex_out, {7'h7F, 7'h7F, 7'h7F, 7'h7F});
    tick_n(1);
    chk("restart_slot0", bus4.hex_out, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    chk("d1_done4", 28'(bus1.scan_done), 28'd1);
    bus1.wr_en = 1'b1; bus1.wr_idx = 3'd1; bus1.wr_data = 4'h8;
    tick_n(1);
    bus1.wr_en = 1'b0;
    tick_n(1);
    chk("d1_idx1_ignored", 28'(bus1.hex_out), 28'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
